dram_cache: RTL and testbench

DRAM_CACHE -- requirements
Module: dram_cache

---
 rtl/dram_cache.sv | 109 ++++++++++
 tb/tb_dram_cache.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cache.sv
// dram_cache: direct-mapped, write-through, no-write-allocate one-word-per-line cache
// sitting between a CPU request port and a DRAM controller request port.
module dram_cache #(
   parameter int INDEX_BITS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_oe,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [3:0]  cpu_we,
   output logic [31:0] cpu_rdata,
   output logic        cpu_valid,
   output logic        cpu_busy,
   output logic        dram_oe,
   output logic [31:0] dram_addr,
   output logic [31:0] dram_wdata,
   output logic [3:0]  dram_we,
   input  logic [31:0] dram_rdata,
   input  logic        dram_valid,
   input  logic        dram_busy,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);
   localparam int LINES = 1 << INDEX_BITS;
   localparam int TW = 30 - INDEX_BITS;
   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT} state_t;
   state_t state, state_n;
   logic [LINES-1:0] valid;
   logic [TW-1:0] tags [LINES];
   logic [31:0] words [LINES];
   logic [31:0] a_addr, a_wdata;
   logic [3:0] a_we, bmask;
   logic [INDEX_BITS-1:0] idx, a_idx;
   logic [TW-1:0] tag, a_tag;
   logic [31:0] wshift, merged;
   logic accept, is_wr, hit, refill;
   assign idx = cpu_addr[2+:INDEX_BITS];
   assign tag = cpu_addr[31-:TW];
   assign a_idx = a_addr[2+:INDEX_BITS];
   assign a_tag = a_addr[31-:TW];
   assign accept = state == IDLE && (cpu_oe || cpu_we[0]);
   assign is_wr = cpu_we[0];
   assign hit = valid[idx] && tags[idx] == tag;
   assign refill = state == RD_WAIT && dram_valid;
   assign bmask = cpu_we << cpu_addr[1:0];
   assign wshift = cpu_wdata << {cpu_addr[1:0], 3'b000};
   // The issue strobe is combinational so the controller's busy, which rises the
   // cycle after the strobe, is already visible on the first wait-state cycle.
   assign dram_oe = (state == RD_ISSUE || state == WR_ISSUE) && !dram_busy;
   assign dram_we = state == WR_ISSUE && !dram_busy ? a_we : 4'b0000;
   assign dram_addr = state == RD_ISSUE ? {a_addr[31:2], 2'b00} : a_addr;
   assign dram_wdata = a_wdata;
   assign cpu_busy = state != IDLE;
   always_comb begin
      merged = words[idx];
      for (int b = 0; b < 4; b++)
         if (bmask[b]) merged[8*b+:8] = wshift[8*b+:8];
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:     if (accept) state_n = is_wr ? WR_ISSUE : (hit ? IDLE : RD_ISSUE);
         RD_ISSUE: if (!dram_busy) state_n = RD_WAIT;
         RD_WAIT:  if (dram_valid) state_n = IDLE;
         WR_ISSUE: if (!dram_busy) state_n = WR_WAIT;
         WR_WAIT:  if (!dram_busy) state_n = IDLE;
         default:  state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         valid <= '0;
         a_addr <= '0;
         a_wdata <= '0;
         a_we <= '0;
         cpu_valid <= 1'b0;
         cpu_rdata <= '0;
         hit_cnt <= '0;
         miss_cnt <= '0;
      end else begin
         state <= state_n;
         cpu_valid <= 1'b0;
         if (accept) begin
            a_addr <= cpu_addr;
            a_wdata <= cpu_wdata;
            a_we <= cpu_we;
         end
         if (accept && !is_wr && hit) begin
            cpu_valid <= 1'b1;
            cpu_rdata <= words[idx] >> {cpu_addr[1:0], 3'b000};
            hit_cnt <= hit_cnt + 32'(hit_cnt != '1);
         end
         if (accept && !is_wr && !hit) miss_cnt <= miss_cnt + 32'(miss_cnt != '1);
         if (refill) begin
            valid[a_idx] <= 1'b1;
            cpu_valid <= 1'b1;
            cpu_rdata <= dram_rdata >> {a_addr[1:0], 3'b000};
         end
      end
   end
   always_ff @(posedge clk) begin
      if (refill) begin
         tags[a_idx] <= a_tag;
         words[a_idx] <= dram_rdata;
      end else if (accept && is_wr && hit) words[idx] <= merged;
   end
endmodule

// File: tb/tb_dram_cache.sv
// tb_dram_cache: vector table plus hand sequences against a behavioural DRAM controller;
// read data is checked through a scoreboard queue popped on each cpu_valid.
module tb_dram_cache;
   logic clk = 0, rst;
   logic cpu_oe, cpu_valid, cpu_busy, dram_oe, dram_valid, dram_busy;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dram_addr, dram_wdata, dram_rdata, hit_cnt, miss_cnt;
   logic [3:0] cpu_we, dram_we;
   always #5 clk = ~clk;

   dram_cache #(.INDEX_BITS(8)) dut (
      .clk(clk), .rst(rst), .cpu_oe(cpu_oe), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_we(cpu_we), .cpu_rdata(cpu_rdata), .cpu_valid(cpu_valid), .cpu_busy(cpu_busy),
      .dram_oe(dram_oe), .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_we(dram_we),
      .dram_rdata(dram_rdata), .dram_valid(dram_valid), .dram_busy(dram_busy),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] wdata;
      logic        hit;
      logic [31:0] exp;
   } vec_t;

   int total = 0, bad = 0;
   int oe_cnt = 0, val_cnt = 0, lat = 3;
   int exp_hit = 0, exp_miss = 0;
   logic [31:0] last_addr, last_wd;
   logic [3:0] last_we;
   logic [31:0] exp_q[$];
   logic [31:0] mem [logic [31:0]];

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endfunction

   function automatic logic [31:0] rd_mem(logic [31:0] a);
      logic [31:0] k = {a[31:2], 2'b00};
      return mem.exists(k) ? mem[k] : 32'h0;
   endfunction

   task automatic wr_mem(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
      logic [3:0] m = 4'(we << a[1:0]);
      logic [31:0] d = wd << {a[1:0], 3'b000};
      logic [31:0] w = rd_mem(a);
      for (int b = 0; b < 4; b++)
         if (m[b]) w[8*b+:8] = d[8*b+:8];
      mem[{a[31:2], 2'b00}] = w;
   endtask

   // DRAM controller: busy from the cycle after the strobe until completion
   initial begin
      logic [31:0] m_addr, m_wd;
      logic [3:0] m_we;
      dram_busy = 0;
      dram_valid = 0;
      dram_rdata = 0;
      forever begin
         @(negedge clk);
         if (dram_oe && !rst) begin
            m_addr = dram_addr;
            m_we = dram_we;
            m_wd = dram_wdata;
            @(posedge clk);
            #1 dram_busy = 1;
            repeat (lat) @(posedge clk);
            #1;
            if (m_we[0]) wr_mem(m_addr, m_we, m_wd);
            else begin
               dram_rdata = rd_mem(m_addr);
               dram_valid = 1;
               @(posedge clk);
               #1 dram_valid = 0;
            end
            dram_busy = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (dram_oe) begin
         oe_cnt++;
         last_addr = dram_addr;
         last_we = dram_we;
         last_wd = dram_wdata;
         chk("oe_while_busy", {31'b0, dram_busy}, 0);
      end else chk("dram_we_idle", {28'b0, dram_we}, 0);
      if (cpu_valid) begin
         val_cnt++;
         chk("busy_at_valid", {31'b0, cpu_busy}, 0);
         if (exp_q.size() == 0) chk("unexpected_valid", cpu_rdata, 32'hxxxxxxxx);
         else chk("rdata", cpu_rdata, exp_q.pop_front());
      end
   end

   task automatic run_vec(input vec_t v);
      int n0, v0, cyc;
      logic dram_txn;
      n0 = oe_cnt;
      v0 = val_cnt;
      dram_txn = v.wr || !v.hit;
      @(negedge clk);
      cpu_addr = v.addr;
      cpu_wdata = v.wdata;
      cpu_we = v.we;
      cpu_oe = !v.wr;
      if (!v.wr) exp_q.push_back(v.exp);
      @(negedge clk);
      cpu_oe = 0;
      cpu_we = 0;
      #1;
      if (!dram_txn) chk("hit_latency", 32'(val_cnt - v0), 1);
      cyc = 0;
      while ((cpu_busy || (!v.wr && val_cnt == v0)) && cyc < 200) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      chk("complete", {31'b0, cyc < 200}, 1);
      chk("dram_reqs", 32'(oe_cnt - n0), dram_txn ? 1 : 0);
      if (dram_txn) begin
         chk("dram_addr", last_addr, v.wr ? v.addr : {v.addr[31:2], 2'b00});
         chk("dram_we", {28'b0, last_we}, v.wr ? {28'b0, v.we} : 0);
         if (v.wr) chk("dram_wdata", last_wd, v.wdata);
      end
      if (!v.wr && v.hit) exp_hit++;
      if (!v.wr && !v.hit) exp_miss++;
      chk("hit_cnt", hit_cnt, 32'(exp_hit));
      chk("miss_cnt", miss_cnt, 32'(exp_miss));
   endtask

   task automatic reset_outputs(input string tag);
      chk({tag, "_cpu_valid"}, {31'b0, cpu_valid}, 0);
      chk({tag, "_cpu_busy"}, {31'b0, cpu_busy}, 0);
      chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
      chk({tag, "_dram_oe"}, {31'b0, dram_oe}, 0);
      chk({tag, "_dram_we"}, {28'b0, dram_we}, 0);
      chk({tag, "_dram_addr"}, dram_addr, 0);
      chk({tag, "_dram_wdata"}, dram_wdata, 0);
      chk({tag, "_hit_cnt"}, hit_cnt, 0);
      chk({tag, "_miss_cnt"}, miss_cnt, 0);
   endtask

   initial begin
      vec_t vecs[13];
      int n0, v0, cyc;
      vecs = '{
         '{0, 32'h0000_1004, 4'b0000, 32'h0, 0, 32'hDEADBEEF},
         '{0, 32'h0000_1004, 4'b0000, 32'h0, 1, 32'hDEADBEEF},
         '{0, 32'h0000_1006, 4'b0000, 32'h0, 1, 32'h0000DEAD},
         '{1, 32'h0000_1005, 4'b0001, 32'h77, 0, 32'h0},
         '{0, 32'h0000_1004, 4'b0000, 32'h0, 1, 32'hDEAD77EF},
         '{1, 32'h0000_2000, 4'b1111, 32'h11223344, 0, 32'h0},
         '{0, 32'h0000_2000, 4'b0000, 32'h0, 0, 32'h11223344},
         '{0, 32'h0004_1004, 4'b0000, 32'h0, 0, 32'h12345678},
         '{0, 32'h0000_1004, 4'b0000, 32'h0, 0, 32'hDEAD77EF},
         '{0, 32'h0000_1007, 4'b0000, 32'h0, 1, 32'h000000DE},
         '{0, 32'h0004_1004, 4'b0000, 32'h0, 0, 32'h12345678},
         '{1, 32'h0004_1006, 4'b0011, 32'hBEEF, 0, 32'h0},
         '{0, 32'h0004_1004, 4'b0000, 32'h0, 1, 32'hBEEF5678}
      };
      mem[32'h0000_1004] = 32'hDEADBEEF;
      mem[32'h0004_1004] = 32'h12345678;
      mem[32'h0000_2000] = 32'hCAFEF00D;
      mem[32'h0000_3000] = 32'hA0A0A0A0;
      mem[32'h0000_5000] = 32'h55AA55AA;
      rst = 1;
      cpu_oe = 0;
      cpu_we = 0;
      cpu_addr = 0;
      cpu_wdata = 0;
      repeat (3) @(negedge clk);
      #1 reset_outputs("por");
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < 13; i++) run_vec(vecs[i]);

      // a request presented while busy must be dropped
      v0 = val_cnt;
      @(negedge clk);
      cpu_oe = 1;
      cpu_addr = 32'h0000_5000;
      exp_q.push_back(32'h55AA55AA);
      @(negedge clk);
      cpu_addr = 32'h0004_1004;
      @(negedge clk);
      cpu_oe = 0;
      cyc = 0;
      while ((cpu_busy || val_cnt == v0) && cyc < 200) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      repeat (3) @(negedge clk);
      #1;
      chk("busy_complete", {31'b0, cyc < 200}, 1);
      chk("busy_valids", 32'(val_cnt - v0), 1);
      chk("busy_hit_cnt", hit_cnt, 5);
      chk("busy_miss_cnt", miss_cnt, 6);

      // reset in RD_WAIT with the DRAM still working on the read
      lat = 15;
      n0 = oe_cnt;
      @(negedge clk);
      cpu_oe = 1;
      cpu_addr = 32'h0000_3000;
      @(negedge clk);
      cpu_oe = 0;
      cyc = 0;
      while (oe_cnt == n0 && cyc < 50) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      repeat (3) @(negedge clk);
      #1;
      chk("rdwait_busy", {31'b0, cpu_busy}, 1);
      chk("rdwait_dram_busy", {31'b0, dram_busy}, 1);
      rst = 1;
      #1 reset_outputs("mid");
      @(negedge clk);
      rst = 0;
      lat = 3;
      exp_q.delete();
      exp_hit = 0;
      exp_miss = 0;
      run_vec('{0, 32'h0000_1004, 4'b0000, 32'h0, 0, 32'hDEAD77EF});
      run_vec('{0, 32'h0000_1004, 4'b0000, 32'h0, 1, 32'hDEAD77EF});
      repeat (20) @(negedge clk);
      #1 chk("queue_empty", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
